boot_loader_ctrl: RTL

Sequences the UART receiver during boot and turns its byte stream into word writes to instruction memory. It supplies the baud divisor, consumes each received byte and acknowledges it via clr_rdy, then parses a framed load packet. It writes the payload words to memory with a handshake, checks an XOR checksum, and holds the CPU in reset until a good frame completes.

---
 rtl/boot_pkg.sv | 20 ++
 rtl/boot_timeout.sv | 29 ++
 rtl/boot_loader_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    LEN_H,
    LEN_L,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
  localparam logic [12:0] BAUD_DIV_DFLT = 13'd434;

endpackage

// File: rtl/boot_timeout.sv
// Inter-byte watchdog: reload on activity, count down while enabled.
module boot_timeout #(
  parameter int unsigned CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = $clog2(CYC + 1);
  localparam logic [W-1:0] INIT = W'(CYC - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= INIT;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Parses framed UART load packets into instruction memory writes.
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter logic [12:0] BAUD_DIV    = BAUD_DIV_DFLT,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rdy,
  output logic [12:0]       baud,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              cpu_rst,
  output logic              boot_done,
  output logic              boot_err
);

  state_t      state_q, state_d;
  logic [7:0]  addr_hi_q;
  logic [7:0]  chk_q;
  logic [15:0] cnt_q;
  logic [1:0]  idx_q;
  logic        run, ack_ev;
  logic        tmo_load, tmo_exp, tmo;

  assign run      = !(state_q inside {IDLE, DONE, ERR});
  assign ack_ev   = mem_ack && (state_q == WRITE);
  assign tmo_load = !run || rx_rdy || ack_ev;
  // A byte or an ack on the expiry cycle counts as activity.
  assign tmo      = tmo_exp && !rx_rdy && !ack_ev;

  boot_timeout #(
    .CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .load  (tmo_load),
    .en    (run),
    .expire(tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ERR:
        if (rx_rdy && rx_data == SYNC_BYTE)
          state_d = ADDR_H;
      ADDR_H: if (rx_rdy) state_d = ADDR_L;
      ADDR_L: if (rx_rdy) state_d = LEN_H;
      LEN_H:  if (rx_rdy) state_d = LEN_L;
      LEN_L:
        if (rx_rdy)
          state_d = ({cnt_q[15:8], rx_data} == 16'd0)
                    ? CHK : DATA;
      DATA:
        if (rx_rdy && idx_q == 2'd3)
          state_d = WRITE;
      WRITE: begin
        unique case (1'b1)
          rx_rdy:  state_d = ERR;
          mem_ack: state_d = (cnt_q == 16'd1) ? CHK : DATA;
          default: ;
        endcase
      end
      CHK:
        if (rx_rdy)
          state_d = (rx_data == chk_q) ? DONE : ERR;
      DONE: ;
      default: state_d = IDLE;
    endcase
    if (tmo) state_d = ERR;
  end

  always_comb begin
    mem_we    = (state_q == WRITE);
    boot_done = (state_q == DONE);
    boot_err  = (state_q == ERR);
    cpu_rst   = (state_q != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_rdy   <= 1'b0;
      baud      <= BAUD_DIV;
      addr_hi_q <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      chk_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else begin
      clr_rdy <= rx_rdy;
      baud    <= BAUD_DIV;
      if (rx_rdy) begin
        unique case (state_q)
          IDLE, ERR:
            if (rx_data == SYNC_BYTE) chk_q <= '0;
          ADDR_H: begin
            addr_hi_q <= rx_data;
            chk_q     <= chk_q ^ rx_data;
          end
          ADDR_L: begin
            mem_addr <= ADDR_W'({addr_hi_q, rx_data});
            chk_q    <= chk_q ^ rx_data;
          end
          LEN_H: begin
            cnt_q[15:8] <= rx_data;
            chk_q       <= chk_q ^ rx_data;
          end
          LEN_L: begin
            cnt_q[7:0] <= rx_data;
            idx_q      <= '0;
            chk_q      <= chk_q ^ rx_data;
          end
          DATA: begin
            mem_wdata[8*idx_q +: 8] <= rx_data;
            idx_q <= idx_q + 2'd1;
            chk_q <= chk_q ^ rx_data;
          end
          default: ;
        endcase
      end else if (ack_ev) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        cnt_q    <= cnt_q - 16'd1;
      end
    end
  end

endmodule
